// File: rtl/exp_pkg.sv
// Shared constants for the WB-stage exception/commit unit: CSR map, cause codes,
// exception-vector bit positions and FSM encoding.
package exp_pkg;

  // Machine-mode trap CSR addresses.
  localparam logic [11:0] CsrMstatus = 12'h300;
  localparam logic [11:0] CsrMie     = 12'h304;
  localparam logic [11:0] CsrMtvec   = 12'h305;
  localparam logic [11:0] CsrMepc    = 12'h341;
  localparam logic [11:0] CsrMcause  = 12'h342;
  localparam logic [11:0] CsrMtval   = 12'h343;

  // Bit positions inside exp_vector_WB.
  localparam int unsigned ExpIll   = 0;
  localparam int unsigned ExpEcall = 1;
  localparam int unsigned ExpLoad  = 2;
  localparam int unsigned ExpStore = 3;
  localparam int unsigned ExpMret  = 4;

  // Exception cause codes (interrupt flag is added by the consumer at XLEN-1).
  localparam int unsigned CauseIll        = 2;
  localparam int unsigned CauseLoadFault  = 5;
  localparam int unsigned CauseStoreFault = 7;
  localparam int unsigned CauseEcall      = 11;
  localparam int unsigned CauseMext       = 11;

  // Implemented bits of mstatus / mie.
  localparam int unsigned MstatusMie  = 3;
  localparam int unsigned MstatusMpie = 7;
  localparam int unsigned MieMeie     = 11;

  typedef enum logic [0:0] {
    StIdle,
    StKill
  } exp_state_e;

endpackage

// File: rtl/csr_file_m.sv
// Machine-mode trap CSR storage. A trap-update port (entry or mret) wins over a
// software write touching the same register in the same cycle.
module csr_file_m
  import exp_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_enter_i,
  input  logic            trap_mret_i,
  input  logic [XLEN-1:0] trap_epc_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic            sw_we_i,
  input  logic [11:0]     sw_addr_i,
  input  logic [XLEN-1:0] sw_wdata_i,
  input  logic [11:0]     raddr_i,
  output logic [XLEN-1:0] rdata_o,
  output logic [XLEN-1:0] trap_base_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            mstatus_mie_o,
  output logic            mie_meie_o
);

  logic            mstatus_mie_q, mstatus_mie_d;
  logic            mstatus_mpie_q, mstatus_mpie_d;
  logic            mie_meie_q, mie_meie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;

  // Next-state: software write first, trap update overrides it.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_meie_d     = mie_meie_q;
    mtvec_d        = mtvec_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    mtval_d        = mtval_q;

    if (sw_we_i) begin
      unique case (sw_addr_i)
        CsrMstatus: begin
          mstatus_mie_d  = sw_wdata_i[MstatusMie];
          mstatus_mpie_d = sw_wdata_i[MstatusMpie];
        end
        CsrMie:    mie_meie_d = sw_wdata_i[MieMeie];
        CsrMtvec:  mtvec_d    = {sw_wdata_i[XLEN-1:2], 2'b00};
        CsrMepc:   mepc_d     = sw_wdata_i;
        CsrMcause: mcause_d   = sw_wdata_i;
        CsrMtval:  mtval_d    = sw_wdata_i;
        default:   ; // unimplemented address: dropped
      endcase
    end

    if (trap_enter_i) begin
      mstatus_mpie_d = mstatus_mie_q;
      mstatus_mie_d  = 1'b0;
      mepc_d         = trap_epc_i;
      mcause_d       = trap_cause_i;
      mtval_d        = trap_tval_i;
    end else if (trap_mret_i) begin
      mstatus_mie_d  = mstatus_mpie_q;
      mstatus_mpie_d = 1'b1;
    end
  end

  // CSR state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_meie_q     <= 1'b0;
      mtvec_q        <= {MTVEC_RST[XLEN-1:2], 2'b00};
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_meie_q     <= mie_meie_d;
      mtvec_q        <= mtvec_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      mtval_q        <= mtval_d;
    end
  end

  // Read mux; unimplemented addresses read as zero, no write bypass.
  always_comb begin
    rdata_o = '0;
    unique case (raddr_i)
      CsrMstatus: begin
        rdata_o[MstatusMie]  = mstatus_mie_q;
        rdata_o[MstatusMpie] = mstatus_mpie_q;
      end
      CsrMie:    rdata_o[MieMeie] = mie_meie_q;
      CsrMtvec:  rdata_o = mtvec_q;
      CsrMepc:   rdata_o = mepc_q;
      CsrMcause: rdata_o = mcause_q;
      CsrMtval:  rdata_o = mtval_q;
      default:   rdata_o = '0;
    endcase
  end

  assign trap_base_o   = mtvec_q;
  assign mepc_o        = mepc_q;
  assign mstatus_mie_o = mstatus_mie_q;
  assign mie_meie_o    = mie_meie_q;

endmodule

// File: rtl/exp_commit_unit.sv
// WB-stage commit/trap decision: detects exceptions, interrupts and mret on the
// WB slot, updates trap CSRs, and issues a one-cycle flush plus PC redirect.
module exp_commit_unit
  import exp_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = 32'h0000_0100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PCurrent_WB,
  input  logic [31:0]     IR_WB,
  input  logic [XLEN-1:0] ALUO_WB,
  input  logic [4:0]      exp_vector_WB,
  input  logic            illegal_addr_WB,
  input  logic            isFlushed,
  input  logic            RegWrite_WB,
  input  logic            ext_int,
  input  logic            csr_we,
  input  logic [11:0]     csr_waddr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic [11:0]     csr_raddr,
  output logic [XLEN-1:0] csr_rdata,
  output logic            RegWrite_o,
  output logic            mem_kill_o,
  output logic            flush_o,
  output logic            redirect_en,
  output logic [XLEN-1:0] redirect_pc
);

  exp_state_e      state_q, state_d;
  logic            flush_q, flush_d;
  logic            redirect_en_q, redirect_en_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

  logic            slot_valid, idle;
  logic            ill_req, ecall_req, ldf_req, stf_req;
  logic            exc_req, mret_req, irq_req, trap_req;
  logic [XLEN-1:0] trap_cause, trap_tval, trap_epc;
  logic [XLEN-1:0] trap_base, mepc;
  logic            mstatus_mie, mie_meie;
  logic            sw_we;

  // Request decode; only evaluated in IDLE so the KILL slot can never trap.
  always_comb begin
    slot_valid = ~isFlushed & (IR_WB != '0);
    idle       = (state_q == StIdle);
    ill_req    = idle & slot_valid & exp_vector_WB[ExpIll];
    ecall_req  = idle & slot_valid & exp_vector_WB[ExpEcall];
    ldf_req    = idle & slot_valid & exp_vector_WB[ExpLoad] & illegal_addr_WB;
    stf_req    = idle & slot_valid & exp_vector_WB[ExpStore] & illegal_addr_WB;
    exc_req    = ill_req | ecall_req | ldf_req | stf_req;
    mret_req   = idle & slot_valid & exp_vector_WB[ExpMret] & ~exc_req;
    irq_req    = idle & slot_valid & ext_int & mstatus_mie & mie_meie & ~exc_req & ~mret_req;
    trap_req   = exc_req | mret_req | irq_req;
  end

  // Cause / tval / epc selection in priority order.
  always_comb begin
    trap_cause = '0;
    trap_tval  = '0;
    trap_epc   = PCurrent_WB;
    if (ill_req) begin
      trap_cause = XLEN'(CauseIll);
      trap_tval  = XLEN'(IR_WB);
    end else if (ecall_req) begin
      trap_cause = XLEN'(CauseEcall);
    end else if (ldf_req) begin
      trap_cause = XLEN'(CauseLoadFault);
      trap_tval  = ALUO_WB;
    end else if (stf_req) begin
      trap_cause = XLEN'(CauseStoreFault);
      trap_tval  = ALUO_WB;
    end else if (irq_req) begin
      // Interrupted instruction commits, so resume after it.
      trap_cause = {1'b1, (XLEN-1)'(CauseMext)};
      trap_epc   = PCurrent_WB + XLEN'(4);
    end
  end

  // Committing CSR write: not from an excepting slot, never in KILL.
  assign sw_we = csr_we & idle & slot_valid & ~exc_req;

  csr_file_m #(
    .XLEN      (XLEN),
    .MTVEC_RST (MTVEC_RST)
  ) u_csr_file (
    .clk           (clk),
    .rst           (rst),
    .trap_enter_i  (exc_req | irq_req),
    .trap_mret_i   (mret_req),
    .trap_epc_i    (trap_epc),
    .trap_cause_i  (trap_cause),
    .trap_tval_i   (trap_tval),
    .sw_we_i       (sw_we),
    .sw_addr_i     (csr_waddr),
    .sw_wdata_i    (csr_wdata),
    .raddr_i       (csr_raddr),
    .rdata_o       (csr_rdata),
    .trap_base_o   (trap_base),
    .mepc_o        (mepc),
    .mstatus_mie_o (mstatus_mie),
    .mie_meie_o    (mie_meie)
  );

  // FSM next-state plus registered flush/redirect outputs.
  always_comb begin
    state_d       = state_q;
    flush_d       = 1'b0;
    redirect_en_d = 1'b0;
    redirect_pc_d = redirect_pc_q;
    unique case (state_q)
      StIdle: begin
        if (trap_req) begin
          state_d       = StKill;
          flush_d       = 1'b1;
          redirect_en_d = 1'b1;
          redirect_pc_d = mret_req ? mepc : trap_base;
        end
      end
      StKill:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM and redirect registers; reset also aborts an in-flight redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      flush_q       <= 1'b0;
      redirect_en_q <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      flush_q       <= flush_d;
      redirect_en_q <= redirect_en_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Write-enable gating and store suppression for killed slots.
  always_comb begin
    RegWrite_o = RegWrite_WB & slot_valid & idle & (~trap_req | irq_req);
    mem_kill_o = trap_req | (state_q == StKill);
  end

  assign flush_o     = flush_q;
  assign redirect_en = redirect_en_q;
  assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_exp_commit_unit.sv
// Directed bench for exp_commit_unit. Redirects are scoreboarded: stimulus pushes
// the expected target, a negedge monitor pops it when redirect_en appears.
module tb_exp_commit_unit;

  logic        clk;
  logic        rst;
  logic [31:0] PCurrent_WB, IR_WB, ALUO_WB;
  logic [4:0]  exp_vector_WB;
  logic        illegal_addr_WB, isFlushed, RegWrite_WB, ext_int, csr_we;
  logic [11:0] csr_waddr, csr_raddr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        RegWrite_o, mem_kill_o, flush_o, redirect_en;
  logic [31:0] redirect_pc;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_redirect_q[$];
  logic        mon_en = 1'b0;

  exp_commit_unit #(
    .XLEN      (32),
    .MTVEC_RST (32'h0000_0100)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .PCurrent_WB     (PCurrent_WB),
    .IR_WB           (IR_WB),
    .ALUO_WB         (ALUO_WB),
    .exp_vector_WB   (exp_vector_WB),
    .illegal_addr_WB (illegal_addr_WB),
    .isFlushed       (isFlushed),
    .RegWrite_WB     (RegWrite_WB),
    .ext_int         (ext_int),
    .csr_we          (csr_we),
    .csr_waddr       (csr_waddr),
    .csr_wdata       (csr_wdata),
    .csr_raddr       (csr_raddr),
    .csr_rdata       (csr_rdata),
    .RegWrite_o      (RegWrite_o),
    .mem_kill_o      (mem_kill_o),
    .flush_o         (flush_o),
    .redirect_en     (redirect_en),
    .redirect_pc     (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every observed redirect must match the oldest expected one.
  always @(negedge clk) begin
    if (mon_en && (redirect_en !== 1'b0 || flush_o !== 1'b0)) begin
      check("flush_eq_redirect_en", {31'd0, flush_o}, {31'd0, redirect_en});
      if (exp_redirect_q.size() == 0) begin
        check("unexpected_redirect", {31'd0, redirect_en}, 32'd0);
      end else begin
        check("redirect_pc", redirect_pc, exp_redirect_q.pop_front());
      end
    end
  end

  task automatic bubble();
    PCurrent_WB     = '0;
    IR_WB           = '0;
    ALUO_WB         = '0;
    exp_vector_WB   = '0;
    illegal_addr_WB = 1'b0;
    isFlushed       = 1'b0;
    RegWrite_WB     = 1'b0;
    ext_int         = 1'b0;
    csr_we          = 1'b0;
    csr_waddr       = '0;
    csr_wdata       = '0;
    csr_raddr       = '0;
  endtask

  task automatic read_csr(input string name, input logic [11:0] addr, input logic [31:0] req);
    @(negedge clk);
    bubble();
    csr_raddr = addr;
    #1;
    check(name, csr_rdata, req);
  endtask

  task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk);
    bubble();
    PCurrent_WB = 32'h60;
    IR_WB       = 32'h0000_1073;
    csr_we      = 1'b1;
    csr_waddr   = addr;
    csr_wdata   = data;
  endtask

  initial begin
    bubble();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_flush", {31'd0, flush_o}, 32'd0);
    check("reset_redirect_en", {31'd0, redirect_en}, 32'd0);
    check("reset_redirect_pc", redirect_pc, 32'd0);
    mon_en = 1'b1;
    read_csr("reset_mtvec", 12'h305, 32'h100);
    read_csr("reset_mstatus", 12'h300, 32'h0);

    // Illegal instruction.
    @(negedge clk);
    bubble();
    PCurrent_WB = 32'h40; IR_WB = 32'hFFFF_FFFF; exp_vector_WB = 5'b00001; RegWrite_WB = 1'b1;
    #1;
    check("ill_regwrite", {31'd0, RegWrite_o}, 32'd0);
    check("ill_mem_kill", {31'd0, mem_kill_o}, 32'd1);
    exp_redirect_q.push_back(32'h100);
    @(negedge clk);
    bubble();
    PCurrent_WB = 32'h44; IR_WB = 32'h0000_0013; RegWrite_WB = 1'b1;
    #1;
    check("ill_kill_regwrite", {31'd0, RegWrite_o}, 32'd0);
    check("ill_kill_mem_kill", {31'd0, mem_kill_o}, 32'd1);
    read_csr("ill_mepc", 12'h341, 32'h40);
    check("ill_flush_drops", {31'd0, flush_o}, 32'd0);
    read_csr("ill_mcause", 12'h342, 32'd2);
    read_csr("ill_mtval", 12'h343, 32'hFFFF_FFFF);

    // Store access fault.
    @(negedge clk);
    bubble();
    PCurrent_WB = 32'h50; IR_WB = 32'h00A1_2023; ALUO_WB = 32'hDEAD_0000;
    exp_vector_WB = 5'b01000; illegal_addr_WB = 1'b1;
    #1;
    check("stf_mem_kill", {31'd0, mem_kill_o}, 32'd1);
    exp_redirect_q.push_back(32'h100);
    read_csr("stf_mcause", 12'h342, 32'd7);
    read_csr("stf_mtval", 12'h343, 32'hDEAD_0000);
    read_csr("stf_mepc", 12'h341, 32'h50);

    // Store without fault commits normally.
    @(negedge clk);
    bubble();
    PCurrent_WB = 32'h54; IR_WB = 32'h00A1_2023; ALUO_WB = 32'h0000_1000;
    exp_vector_WB = 5'b01000; RegWrite_WB = 1'b1;
    #1;
    check("store_ok_mem_kill", {31'd0, mem_kill_o}, 32'd0);
    check("store_ok_regwrite", {31'd0, RegWrite_o}, 32'd1);
    @(negedge clk);
    bubble();
    #1;
    check("store_ok_no_flush", {31'd0, flush_o}, 32'd0);

    // Enable and take the external interrupt.
    csr_write(12'h300, 32'h8);
    csr_write(12'h304, 32'h800);
    read_csr("irq_mstatus_set", 12'h300, 32'h8);
    read_csr("irq_mie_set", 12'h304, 32'h800);
    @(negedge clk);
    bubble();
    PCurrent_WB = 32'h80; IR_WB = 32'h0000_0013; RegWrite_WB = 1'b1; ext_int = 1'b1;
    #1;
    check("irq_regwrite", {31'd0, RegWrite_o}, 32'd1);
    check("irq_mem_kill", {31'd0, mem_kill_o}, 32'd1);
    exp_redirect_q.push_back(32'h100);
    read_csr("irq_mepc", 12'h341, 32'h84);
    read_csr("irq_mcause", 12'h342, 32'h8000_000B);
    read_csr("irq_mstatus", 12'h300, 32'h80);
    read_csr("irq_mtval", 12'h343, 32'h0);

    // mret back to 0x84, younger slot in KILL must not write.
    @(negedge clk);
    bubble();
    PCurrent_WB = 32'h100; IR_WB = 32'h3020_0073; exp_vector_WB = 5'b10000;
    #1;
    check("mret_mem_kill", {31'd0, mem_kill_o}, 32'd1);
    exp_redirect_q.push_back(32'h84);
    @(negedge clk);
    bubble();
    PCurrent_WB = 32'h104; IR_WB = 32'h0000_0013; RegWrite_WB = 1'b1;
    #1;
    check("mret_kill_regwrite", {31'd0, RegWrite_o}, 32'd0);
    read_csr("mret_mstatus", 12'h300, 32'h88);

    // Flushed slot carrying ecall: no trap.
    @(negedge clk);
    bubble();
    PCurrent_WB = 32'h88; IR_WB = 32'h0000_0073; exp_vector_WB = 5'b00010;
    isFlushed = 1'b1; RegWrite_WB = 1'b1;
    #1;
    check("flushed_mem_kill", {31'd0, mem_kill_o}, 32'd0);
    check("flushed_regwrite", {31'd0, RegWrite_o}, 32'd0);
    @(negedge clk);
    bubble();
    #1;
    check("flushed_no_flush", {31'd0, flush_o}, 32'd0);

    // ecall with a simultaneous mtvec write: write dropped.
    @(negedge clk);
    bubble();
    PCurrent_WB = 32'h90; IR_WB = 32'h0000_0073; exp_vector_WB = 5'b00010;
    csr_we = 1'b1; csr_waddr = 12'h305; csr_wdata = 32'h203;
    exp_redirect_q.push_back(32'h100);
    read_csr("ecall_mtvec", 12'h305, 32'h100);
    read_csr("ecall_mcause", 12'h342, 32'd11);
    read_csr("ecall_mepc", 12'h341, 32'h90);

    // Plain mtvec write with low bits forced to zero; unimplemented CSR ignored.
    csr_write(12'h305, 32'h203);
    read_csr("mtvec_aligned", 12'h305, 32'h200);
    csr_write(12'h7C0, 32'h1234);
    read_csr("unimpl_read_zero", 12'h7C0, 32'h0);

    // Trap to new vector, then reset while in KILL.
    @(negedge clk);
    bubble();
    PCurrent_WB = 32'hA0; IR_WB = 32'hFFFF_FFFF; exp_vector_WB = 5'b00001;
    exp_redirect_q.push_back(32'h200);
    @(negedge clk);
    bubble();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bubble();
    #1;
    check("rst_kill_flush", {31'd0, flush_o}, 32'd0);
    check("rst_kill_redirect_en", {31'd0, redirect_en}, 32'd0);
    check("rst_kill_redirect_pc", redirect_pc, 32'd0);
    read_csr("rst_mtvec", 12'h305, 32'h100);
    read_csr("rst_mstatus", 12'h300, 32'h0);
    read_csr("rst_mie", 12'h304, 32'h0);
    read_csr("rst_mepc", 12'h341, 32'h0);
    read_csr("rst_mcause", 12'h342, 32'h0);
    read_csr("rst_mtval", 12'h343, 32'h0);

    @(negedge clk);
    check("redirect_queue_drained", exp_redirect_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exp_commit_unit.md
Name: exp_commit_unit

Overview:
- WB-stage consumer of the MEM/WB latch outputs: PC, instruction, ALU result, exception vector, illegal-address flag and flushed flag.
- Decides commit vs. trap for each WB slot and holds the machine-mode trap CSRs (mstatus, mie, mtvec, mepc, mcause, mtval).
- Drives the pipeline-wide flush and the PC redirect for trap entry and mret.
- Gates the register-file write enable of killed instructions.

Parameters:
- XLEN, 32, datapath width.
- MTVEC_RST, 32'h0000_0100, reset value of mtvec.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- PCurrent_WB  in  XLEN  PC of the WB instruction.
- IR_WB  in  32  WB instruction; 0 = bubble.
- ALUO_WB  in  XLEN  effective address / ALU result.
- exp_vector_WB  in  5  exception bits: [0] illegal instr, [1] ecall, [2] load, [3] store, [4] mret.
- illegal_addr_WB  in  1  access fault on the load/store in WB.
- isFlushed  in  1  WB slot is a flushed bubble.
- RegWrite_WB  in  1  raw register write request.
- ext_int  in  1  level machine external interrupt.
- csr_we  in  1  CSR write commit from the WB instruction.
- csr_waddr  in  12  CSR write address.
- csr_wdata  in  XLEN  CSR write data.
- csr_raddr  in  12  CSR read address (EX stage).
- csr_rdata  out  XLEN  CSR read data, combinational.
- RegWrite_o  out  1  gated register write enable.
- mem_kill_o  out  1  combinational; suppresses the store in MEM.
- flush_o  out  1  registered flush to IF/ID, ID/EX, EX/MEM and MEM/WB.
- redirect_en  out  1  registered PC-load strobe.
- redirect_pc  out  XLEN  redirect target.

Behaviour:
- Valid slot: v = ~isFlushed & (IR_WB != 0).
- Trap request in IDLE (combinational, cycle T), by priority:
  - ill = v & exp_vector_WB[0]; cause 2.
  - ecall = v & [1]; cause 11.
  - load fault = v & [2] & illegal_addr_WB; cause 5.
  - store fault = v & [3] & illegal_addr_WB; cause 7.
  - mret = v & [4].
  - irq = v & ext_int & mstatus.MIE & mie.MEIE, with no exception; cause 32'h8000_000B.
  - Bits [2]/[3] without illegal_addr_WB are not traps.
- FSM states: IDLE, KILL. Reset -> IDLE.
- IDLE, any request at edge T+1:
  - Exception: mepc <= PCurrent_WB; mcause <= code; mtval <= ALUO_WB for faults, IR_WB for illegal instr, 0 otherwise.
  - Interrupt: mepc <= PCurrent_WB+4; the WB instruction commits.
  - Exception or interrupt: MPIE <= MIE; MIE <= 0; redirect_pc <= {mtvec[XLEN-1:2],2'b00}.
  - mret: MIE <= MPIE; MPIE <= 1; redirect_pc <= mepc.
  - flush_o <= 1; redirect_en <= 1; state -> KILL.
- KILL (exactly 1 cycle):
  - Slot in WB is younger than the trap: RegWrite_o = 0, CSR writes ignored, no new trap detection.
  - flush_o and redirect_en return to 0 at next edge; state -> IDLE.
- mem_kill_o = trap request in IDLE | (state == KILL).
- RegWrite_o:
  - RegWrite_WB & v in IDLE with no request.
  - RegWrite_WB & v with an interrupt request.
  - 0 for an excepting instruction and in KILL.
- CSR write:
  - Accepted only in IDLE, with v, with no exception request.
  - Trap CSR update has priority over csr_we in the same cycle.
  - mtvec low 2 bits forced to 0.
  - Writes to unimplemented addresses are dropped.
- CSR read of an unimplemented address returns 0. A write is visible on csr_rdata the cycle after its edge; no bypass.
- Reset:
  - All CSRs 0 except mtvec = MTVEC_RST.
  - flush_o = 0, redirect_en = 0, redirect_pc = 0, state IDLE.
  - Reset asserted in KILL aborts the redirect; the next cycle shows flush_o = 0.
- Back-to-back: a trap on the slot immediately after a trap is impossible, because KILL masks it. The next eligible slot is T+2.

Decomposition:
- Package exp_pkg: cause codes, CSR addresses (0x300 mstatus, 0x304 mie, 0x305 mtvec, 0x341 mepc, 0x342 mcause, 0x343 mtval), exp_vector bit indices, FSM state encoding.
- Sub-module csr_file_m: CSR storage, read mux and write arbitration, with a trap-update port and a software-write port.

Test Plan:
- Illegal instruction: PCurrent_WB = 0x40, IR_WB = 0xFFFFFFFF, vec = 5'b00001 -> next cycle mepc = 0x40, mcause = 2, mtval = 0xFFFFFFFF, flush_o = 1, redirect_en = 1, redirect_pc = 0x100, RegWrite_o = 0 throughout.
- Store fault: vec = 5'b01000, illegal_addr_WB = 1, ALUO_WB = 0xDEAD0000 -> mem_kill_o = 1 in cycle T, mcause = 7, mtval = 0xDEAD0000. Same vec with illegal_addr_WB = 0 -> no trap, normal commit.
- Interrupt: write mstatus = 0x8 and mie = 0x800, raise ext_int with PC 0x80 committing RegWrite_WB = 1 -> RegWrite_o = 1, mepc = 0x84, mcause = 0x8000000B, MIE = 0, MPIE = 1.
- mret after the interrupt: vec = 5'b10000 -> redirect_pc = 0x84, MIE = 1. Slot in KILL with RegWrite_WB = 1 -> RegWrite_o = 0.
- isFlushed = 1 with vec = 5'b00010 -> no trap, no flush. csr_we to 0x305 with 0x203 in the same cycle as an ecall -> mtvec unchanged, mcause = 11.
- rst asserted during KILL -> next cycle flush_o = 0, redirect_en = 0, mtvec = 0x100, all other CSRs = 0.
